// File: rtl/sp_pkg.sv
// Shared types and helpers for the service-processor Wishbone width down-converter.
// Lane 0 is the most significant byte of the 32-bit master word.
package sp_pkg;

    typedef enum logic [1:0] {
        SP_DS_IDLE,
        SP_DS_BEAT,
        SP_DS_DONE
    } sp_ds_state_e;

    localparam int unsigned SP_BUS_WIDTH = 32;
    localparam int unsigned SP_MAX_BEATS = 4;

    function automatic int unsigned nbeat(input int unsigned width);
        return SP_BUS_WIDTH / width;
    endfunction

    function automatic logic beat_active(input logic [0:3] sel, input int unsigned k,
                                         input int unsigned width);
        int unsigned lanes;
        logic any;
        lanes = width / 8;
        any = 1'b0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (i >= k * lanes && i < (k + 1) * lanes) begin
                any = any | sel[i];
            end
        end
        return any;
    endfunction

endpackage

// File: rtl/sp_ds_next_beat.sv
// Priority finder: lowest active beat index at or above start.
// The top uses start = 0 for the first beat and pointer + 1 to advance.
module sp_ds_next_beat
    import sp_pkg::*;
(
    input  logic [SP_MAX_BEATS-1:0] mask,
    input  logic [2:0]              start,
    output logic [1:0]              ptr,
    output logic                    valid
);

    always_comb begin
        ptr   = 2'd0;
        valid = 1'b0;
        // Descending scan so the lowest qualifying index is the last one written.
        for (int k = SP_MAX_BEATS - 1; k >= 0; k--) begin
            if (mask[k] && (3'(k) >= start)) begin
                ptr   = 2'(k);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sp_wb_downsizer.sv
// Wishbone classic 32-bit to 8/16-bit down-converter with lane skipping,
// slave error propagation and a per-beat watchdog.
module sp_wb_downsizer
    import sp_pkg::*;
#(
    parameter int unsigned SLAVE_WIDTH     = 8,
    parameter logic [7:0]  WINDOW          = 8'h80,
    parameter bit          SKIP_UNSELECTED = 1'b1,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [0:31]                m_adr_i,
    input  logic [0:31]                m_dat_i,
    input  logic [0:3]                 m_sel_i,
    input  logic                       m_we_i,
    input  logic                       m_stb_i,
    input  logic                       m_cyc_i,
    output logic [0:31]                m_dat_o,
    output logic                       m_ack_o,
    output logic                       m_err_o,
    output logic [0:23]                s_adr_o,
    output logic [0:SLAVE_WIDTH-1]     s_dat_o,
    input  logic [0:SLAVE_WIDTH-1]     s_dat_i,
    output logic [0:SLAVE_WIDTH/8-1]   s_sel_o,
    output logic                       s_we_o,
    output logic                       s_stb_o,
    output logic                       s_cyc_o,
    input  logic                       s_ack_i,
    input  logic                       s_err_i
);

    localparam int unsigned NBEAT = nbeat(SLAVE_WIDTH);
    localparam int unsigned LANES = SLAVE_WIDTH / 8;

    sp_ds_state_e state_q;
    logic [1:0]   ptr_q;
    logic [0:31]  rd_q;
    logic [9:0]   wd_q;
    logic         ack_q;
    logic         err_q;

    logic [SP_MAX_BEATS-1:0] mask;
    logic [2:0]              search_start;
    logic [1:0]              found_ptr;
    logic                    found_valid;
    logic                    bus_held;
    logic                    req;
    logic                    timeout_hit;
    logic [1:0]              beat_off;
    logic                    unused_adr;

    always_comb begin
        mask = '0;
        for (int unsigned k = 0; k < NBEAT; k++) begin
            mask[k] = !SKIP_UNSELECTED || beat_active(m_sel_i, k, SLAVE_WIDTH);
        end
    end

    assign bus_held     = m_cyc_i && m_stb_i;
    assign req          = (state_q == SP_DS_IDLE) && bus_held && (m_adr_i[0:7] == WINDOW);
    assign search_start = (state_q == SP_DS_IDLE) ? 3'd0 : ({1'b0, ptr_q} + 3'd1);
    assign timeout_hit  = (TIMEOUT != 0) && (wd_q == 10'(TIMEOUT));

    sp_ds_next_beat u_next_beat (
        .mask  (mask),
        .start (search_start),
        .ptr   (found_ptr),
        .valid (found_valid)
    );

    assign beat_off   = (LANES == 2) ? {ptr_q[0], 1'b0} : ptr_q;
    assign s_adr_o    = {m_adr_i[8:29], beat_off};
    assign unused_adr = ^m_adr_i[30:31];
    assign s_we_o     = m_we_i;
    assign s_stb_o    = (state_q == SP_DS_BEAT);
    assign s_cyc_o    = (state_q == SP_DS_BEAT);
    assign m_dat_o    = rd_q;
    assign m_ack_o    = ack_q;
    assign m_err_o    = err_q;

    always_comb begin
        s_dat_o = '0;
        s_sel_o = '0;
        for (int unsigned k = 0; k < NBEAT; k++) begin
            if (ptr_q == 2'(k)) begin
                s_dat_o = m_dat_i[k*SLAVE_WIDTH +: SLAVE_WIDTH];
                s_sel_o = m_sel_i[k*LANES +: LANES];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= SP_DS_IDLE;
            ptr_q   <= 2'd0;
            rd_q    <= '0;
            wd_q    <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            unique case (state_q)
                SP_DS_IDLE: begin
                    if (req) begin
                        rd_q <= '0;
                        wd_q <= '0;
                        if (found_valid) begin
                            ptr_q   <= found_ptr;
                            state_q <= SP_DS_BEAT;
                        end else begin
                            state_q <= SP_DS_DONE;
                            ack_q   <= 1'b1;
                        end
                    end
                end
                SP_DS_BEAT: begin
                    if (!bus_held) begin
                        state_q <= SP_DS_IDLE;
                    end else if (s_err_i || timeout_hit) begin
                        state_q <= SP_DS_DONE;
                        err_q   <= 1'b1;
                    end else if (s_ack_i) begin
                        for (int unsigned k = 0; k < NBEAT; k++) begin
                            if (ptr_q == 2'(k)) begin
                                rd_q[k*SLAVE_WIDTH +: SLAVE_WIDTH] <= s_dat_i;
                            end
                        end
                        wd_q <= '0;
                        if (found_valid) begin
                            ptr_q <= found_ptr;
                        end else begin
                            state_q <= SP_DS_DONE;
                            ack_q   <= 1'b1;
                        end
                    end else begin
                        wd_q <= wd_q + 10'd1;
                    end
                end
                SP_DS_DONE: begin
                    state_q <= SP_DS_IDLE;
                end
                default: begin
                    state_q <= SP_DS_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sp_wb_downsizer.sv
// Self-checking bench: an 8-bit (short watchdog) and a 16-bit instance share one master,
// with a transaction-level model predicting beats, termination cycle and read data.
module tb_sp_wb_downsizer;

    localparam int unsigned T8 = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] m_adr, m_dat;
    logic [3:0]  m_sel;
    logic        m_we, m_stb, m_cyc;
    logic        use16;
    logic        s_ack, s_err;
    logic [15:0] rdata;

    int n_checks = 0;
    int n_fail = 0;

    logic [0:31] d8_mdat, d16_mdat;
    logic        d8_ack, d8_err, d16_ack, d16_err;
    logic [0:23] d8_adr, d16_adr;
    logic [0:7]  d8_sdat;
    logic [0:15] d16_sdat;
    logic [0:0]  d8_sel;
    logic [0:1]  d16_sel;
    logic        d8_we, d8_stb, d8_cyc, d16_we, d16_stb, d16_cyc;

    always #5 clk = ~clk;

    sp_wb_downsizer #(.SLAVE_WIDTH(8), .TIMEOUT(T8)) u_dut8 (
        .clk(clk), .reset(reset),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc & ~use16),
        .m_dat_o(d8_mdat), .m_ack_o(d8_ack), .m_err_o(d8_err),
        .s_adr_o(d8_adr), .s_dat_o(d8_sdat), .s_dat_i(rdata[15:8]), .s_sel_o(d8_sel),
        .s_we_o(d8_we), .s_stb_o(d8_stb), .s_cyc_o(d8_cyc),
        .s_ack_i(s_ack & ~use16), .s_err_i(s_err & ~use16)
    );

    sp_wb_downsizer #(.SLAVE_WIDTH(16)) u_dut16 (
        .clk(clk), .reset(reset),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_sel_i(m_sel), .m_we_i(m_we),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc & use16),
        .m_dat_o(d16_mdat), .m_ack_o(d16_ack), .m_err_o(d16_err),
        .s_adr_o(d16_adr), .s_dat_o(d16_sdat), .s_dat_i(rdata), .s_sel_o(d16_sel),
        .s_we_o(d16_we), .s_stb_o(d16_stb), .s_cyc_o(d16_cyc),
        .s_ack_i(s_ack & use16), .s_err_i(s_err & use16)
    );

    logic [31:0] o_mdat;
    logic [23:0] o_adr;
    logic [15:0] o_wdat;
    logic [1:0]  o_sel;
    logic        o_ack, o_err, o_stb, o_cyc, o_we;

    assign o_mdat = use16 ? d16_mdat : d8_mdat;
    assign o_adr  = use16 ? d16_adr : d8_adr;
    assign o_wdat = use16 ? d16_sdat : {d8_sdat, 8'h00};
    assign o_sel  = use16 ? d16_sel : {d8_sel, 1'b0};
    assign o_ack  = use16 ? d16_ack : d8_ack;
    assign o_err  = use16 ? d16_err : d8_err;
    assign o_stb  = use16 ? d16_stb : d8_stb;
    assign o_cyc  = use16 ? d16_cyc : d8_cyc;
    assign o_we   = use16 ? d16_we : d8_we;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] lane(input logic [31:0] v, input int i);
        return v[31-8*i -: 8];
    endfunction

    function automatic logic lane_sel(input logic [3:0] sel, input int i);
        return (i < 4) ? sel[3-i] : 1'b0;
    endfunction

    // One master access against the model; slave waits are random up to maxwait.
    task automatic run_txn(input bit w16, input logic [31:0] adr, input bit we,
                           input logic [3:0] sel, input logic [31:0] wdat,
                           input logic [31:0] rword, input int err_at, input bit hang,
                           input int unsigned maxwait);
        int lanes, nb, c, bi, k, wleft, wtot, exp_c, exp_beats;
        int act[$];
        bit fresh, done, exp_err, any;
        logic got_ack, got_err;
        logic [31:0] lmask;
        logic [15:0] exp_w;
        logic [1:0] exp_s;
        lanes = w16 ? 2 : 1;
        nb = 4 / lanes;
        for (int b = 0; b < nb; b++) begin
            any = 1'b0;
            for (int j = 0; j < lanes; j++) any = any | lane_sel(sel, b * lanes + j);
            if (any) act.push_back(b);
        end
        use16 = w16; m_adr = adr; m_we = we; m_sel = sel; m_dat = wdat;
        m_cyc = 1'b1; m_stb = 1'b1;
        c = 0; bi = 0; fresh = 1'b1; done = 1'b0; wtot = 0; lmask = '0;
        got_ack = 1'b0; got_err = 1'b0;
        wleft = hang ? 0 : int'($urandom_range(maxwait, 0));
        while (!done && c < 40) begin
            @(negedge clk);
            c++;
            s_ack = 1'b0; s_err = 1'b0;
            if (o_ack || o_err) begin
                done = 1'b1; got_ack = o_ack; got_err = o_err;
            end else if (o_stb) begin
                if (fresh) begin
                    fresh = 1'b0;
                    if (bi < act.size()) begin
                        k = act[bi];
                        exp_w = {lane(wdat, k * lanes), w16 ? lane(wdat, k * lanes + 1) : 8'h00};
                        exp_s = {lane_sel(sel, k * lanes), w16 ? lane_sel(sel, k * lanes + 1) : 1'b0};
                        check_eq("s_adr", o_adr, {adr[23:2], 2'(k * lanes)});
                        check_eq("s_dat", o_wdat, exp_w);
                        check_eq("s_sel", o_sel, exp_s);
                        check_eq("s_we", o_we, we);
                        check_eq("s_cyc", o_cyc, 1);
                    end else begin
                        check_eq("extra_beat", bi, act.size());
                    end
                end
                if (!hang && bi < act.size()) begin
                    if (wleft > 0) begin
                        wleft--; wtot++;
                    end else begin
                        k = act[bi];
                        rdata = {lane(rword, k * lanes), w16 ? lane(rword, k * lanes + 1) : 8'h00};
                        if (bi == err_at) s_err = 1'b1;
                        else begin
                            s_ack = 1'b1;
                            for (int j = 0; j < lanes; j++) lmask[31-8*(k*lanes+j) -: 8] = 8'hFF;
                        end
                        bi++; fresh = 1'b1;
                        wleft = int'($urandom_range(maxwait, 0));
                    end
                end
            end
        end
        s_ack = 1'b0; s_err = 1'b0; m_cyc = 1'b0; m_stb = 1'b0;
        if (hang) begin
            exp_err = 1'b1; exp_c = 2 + T8; exp_beats = 0;
        end else if (err_at >= 0 && err_at < act.size()) begin
            exp_err = 1'b1; exp_c = 2 + err_at + wtot; exp_beats = err_at + 1;
        end else begin
            exp_err = 1'b0; exp_c = 1 + act.size() + wtot; exp_beats = act.size();
        end
        check_eq("terminated", done, 1);
        check_eq("m_ack", got_ack, !exp_err);
        check_eq("m_err", got_err, exp_err);
        check_eq("term_cycle", c, exp_c);
        check_eq("beats", bi, exp_beats);
        check_eq("m_dat", o_mdat, rword & lmask);
        @(negedge clk);
        check_eq("ack_pulse", o_ack, 0);
        check_eq("err_pulse", o_err, 0);
        check_eq("idle_stb", o_stb, 0);
        check_eq("m_dat_hold", o_mdat, rword & lmask);
    endtask

    initial begin
        bit w16, we;
        int err_at;
        logic [3:0] sel;
        logic [31:0] adr;
        m_adr = '0; m_dat = '0; m_sel = '0; m_we = 1'b0; m_stb = 1'b0; m_cyc = 1'b0;
        use16 = 1'b0; s_ack = 1'b0; s_err = 1'b0; rdata = '0;
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            use16 = u[0];
            #1;
            check_eq("rst_ack", o_ack, 0);
            check_eq("rst_err", o_err, 0);
            check_eq("rst_stb", o_stb, 0);
            check_eq("rst_cyc", o_cyc, 0);
            check_eq("rst_mdat", o_mdat, 0);
        end
        use16 = 1'b0;
        reset = 1'b1;
        @(negedge clk);

        run_txn(0, 32'h8000_1230, 0, 4'hF, 32'h0, 32'h1234_5678, -1, 0, 0);
        run_txn(1, 32'h80AB_CD04, 1, 4'b0011, 32'hDEAD_BEEF, 32'h5A5A_A5A5, -1, 0, 0);
        run_txn(0, 32'h8000_0040, 0, 4'h0, 32'h0, 32'hFFFF_FFFF, -1, 0, 0);
        run_txn(0, 32'h8000_0080, 0, 4'hF, 32'h0, 32'hCAFE_F00D, 1, 0, 0);
        run_txn(0, 32'h8000_00C0, 0, 4'hF, 32'h0, 32'h0, -1, 1, 0);

        // Address outside the window must be ignored.
        use16 = 1'b0; m_adr = 32'h4000_0000; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check_eq("win_stb", o_stb, 0);
            check_eq("win_term", o_ack | o_err, 0);
        end
        m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);

        // Master drops cyc mid-beat.
        m_adr = 32'h8000_0200; m_sel = 4'hF; m_we = 1'b0; m_cyc = 1'b1; m_stb = 1'b1;
        @(negedge clk);
        check_eq("abort_stb_up", o_stb, 1);
        @(negedge clk);
        m_cyc = 1'b0;
        @(negedge clk);
        check_eq("abort_stb", o_stb, 0);
        repeat (3) begin
            @(negedge clk);
            check_eq("abort_term", o_ack | o_err, 0);
        end
        check_eq("abort_mdat", o_mdat, 0);
        m_stb = 1'b0;

        // Reset asserted mid-transfer after one beat landed.
        m_adr = 32'h8000_0300; m_sel = 4'hF; m_cyc = 1'b1; m_stb = 1'b1;
        @(negedge clk);
        check_eq("rabort_stb", o_stb, 1);
        rdata = 16'hAA00; s_ack = 1'b1;
        @(negedge clk);
        s_ack = 1'b0;
        check_eq("rabort_partial", o_mdat, 32'hAA00_0000);
        reset = 1'b0;
        @(negedge clk);
        check_eq("rabort_ack", o_ack, 0);
        check_eq("rabort_err", o_err, 0);
        check_eq("rabort_stb0", o_stb, 0);
        check_eq("rabort_cyc", o_cyc, 0);
        check_eq("rabort_mdat", o_mdat, 0);
        reset = 1'b1; m_cyc = 1'b0; m_stb = 1'b0;
        @(negedge clk);

        for (int n = 0; n < 40; n++) begin
            w16 = 1'($urandom_range(1, 0));
            we = 1'($urandom_range(1, 0));
            sel = 4'($urandom);
            if ($urandom_range(4, 0) == 0) sel = 4'h0;
            adr = $urandom;
            adr[31:24] = 8'h80;
            err_at = ($urandom_range(4, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            run_txn(w16, adr, we, sel, $urandom, $urandom, err_at, 0, 2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sp_wb_downsizer.md
# sp_wb_downsizer

Parametrised Wishbone classic width down-converter between the 32-bit service-processor data bus and a narrower peripheral bus of 8 or 16 bits. Each master access is split into SLAVE_WIDTH-wide beats, and read beats are reassembled into a 32-bit word. Unlike the fixed four-beat byte adapter it replaces, it supports configurable slave width and address window, skips beats whose byte lanes are all deselected, propagates slave errors, and has a watchdog timeout. It sits between the CPU data port and the external 8/16-bit bus, in parallel with the memory and MMIO decoders.

## Interface
Parameters:
- SLAVE_WIDTH, 8: slave data width; legal values are 8 or 16.
- WINDOW, 8'h80: value of m_adr_i[0:7] that selects this bridge.
- SKIP_UNSELECTED, 1: 1 = beats with no selected lanes are not issued; 0 = every beat is issued.
- TIMEOUT, 255: maximum wait cycles per beat before the bridge signals an error; 0 disables the watchdog; range 0..1023.

Ports (bit 0 = MSB throughout):
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low reset.
- m_adr_i  in  [0:31]  master byte address.
- m_dat_i  in  [0:31]  master write data.
- m_sel_i  in  [0:3]  byte lane selects; lane 0 = bits 0:7.
- m_we_i / m_stb_i / m_cyc_i  in  1  Wishbone classic controls.
- m_dat_o  out  [0:31]  assembled read data.
- m_ack_o / m_err_o  out  1  single-cycle termination pulses.
- s_adr_o  out  [0:23]  slave byte address = {m_adr_i[8:29], beat byte offset[0:1]}.
- s_dat_o  out  [0:SLAVE_WIDTH-1]  write data lanes for the current beat.
- s_dat_i  in  [0:SLAVE_WIDTH-1]  slave read data.
- s_sel_o  out  [0:SLAVE_WIDTH/8-1]  m_sel_i lanes for the current beat.
- s_we_o  out  1  equals m_we_i.
- s_stb_o / s_cyc_o  out  1  asserted only in state BEAT.
- s_ack_i / s_err_i  in  1  slave termination.

## Operation
- NBEAT = 32/SLAVE_WIDTH; L = SLAVE_WIDTH/8 lanes per beat. Beat k covers lanes k*L..k*L+L-1 and has byte offset k*L.
- A beat is active if SKIP_UNSELECTED=0, or if any of its lanes has m_sel_i set.
- A request is m_cyc_i & m_stb_i & (m_adr_i[0:7]==WINDOW) while in state IDLE.
- FSM states: IDLE, BEAT, DONE.
  - IDLE: on a request, clear the read register and the watchdog. Load the beat pointer with the first active beat and go to BEAT. If no beat is active, go directly to DONE with ack and issue no slave cycle.
  - BEAT:
    - s_ack_i: write s_dat_i into the read register lanes of the current beat. Advance to the next active beat (priority search upward). If no active beat remains, go to DONE with ack.
    - s_err_i, or watchdog reaches TIMEOUT: go to DONE with err; remaining beats are dropped.
    - s_err_i has priority over a simultaneous s_ack_i.
    - m_cyc_i or m_stb_i falling: abort to IDLE with no termination and no write to the read register.
  - DONE: pulse m_ack_o or m_err_o for one cycle, then go to IDLE.
- m_dat_o holds the read register. Skipped lanes read 8'h00. m_dat_o is stable from DONE until the next request.
- Writes: s_dat_o and s_sel_o are driven combinationally from m_dat_i and m_sel_i at the current beat pointer.
- Reset: state = IDLE, beat pointer = 0, read register = 0, watchdog = 0.
- Reset values of outputs: m_ack_o=0, m_err_o=0, s_stb_o=0, s_cyc_o=0, m_dat_o=0. Reset asserted mid-transfer aborts silently.

## Timing
- The request is registered: s_stb_o rises 1 cycle after the request is first seen.
- With a zero-wait slave (s_ack_i in the same cycle as s_stb_o), each beat takes 1 cycle.
- m_ack_o asserts at cycle 1 + (active beats) after the request cycle:
  - 5 for an 8-bit slave with all lanes selected;
  - 3 for a 16-bit slave with all lanes selected;
  - 1 when no lane is selected.
- The master must drop m_stb_i in the cycle after m_ack_o. The bridge does not re-accept a request until it has returned to IDLE, which takes at least 1 cycle after DONE.
- Watchdog: counts cycles in BEAT without a termination. The count resets on every beat advance. err asserts in the cycle after the count reaches TIMEOUT.
- The slave bus has no pipelining: at most one beat is outstanding.

## Structure
- Shared package sp_pkg holds:
  - the state enum (SP_DS_IDLE, SP_DS_BEAT, SP_DS_DONE);
  - the function nbeat(width);
  - the function beat_active(sel, k, width).
- One sub-module, sp_ds_next_beat: a combinational priority finder. Inputs are the active-beat mask and the current pointer; outputs are the next pointer and a valid flag. It is used both for the first-beat load and for each advance.
- The watchdog is a 10-bit counter, compared against TIMEOUT.

## Test plan
- SLAVE_WIDTH=8, read with sel=4'hF, slave returns 12,34,56,78 with zero wait → s_adr_o offsets 0,1,2,3; m_dat_o=32'h12345678; m_ack_o at cycle 5.
- SLAVE_WIDTH=16, write 32'hDEADBEEF with sel=4'b0011 and SKIP_UNSELECTED=1 → one beat only: offset 2, s_dat_o=16'hBEEF, s_sel_o=2'b11; m_ack_o at cycle 2.
- SLAVE_WIDTH=8, sel=4'h0 → no s_stb_o; m_ack_o at cycle 1; m_dat_o=0.
- s_err_i on beat 1 of 4 → m_err_o pulses once; beats 2 and 3 are never issued; m_ack_o never asserts.
- TIMEOUT=4 with a slave that never acks → m_err_o exactly 5 cycles after s_stb_o rises.
- Either abort → bus idle: drop m_cyc_i mid-beat, then s_stb_o=0 next cycle and no termination; or assert reset low mid-beat, then all outputs 0 the next cycle.
